// File: rtl/conv3x3_stream_param.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream_param
// Desc     : Streaming 3x3 valid-mode convolution with two-row line buffers,
//            a 3x3 window and a 2-stage multiply/add pipeline.
//            Optional ReLU on the output when CONV_RELU_EN is defined.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module conv3x3_stream_param #(
    parameter int IMG_W  = 14,
    parameter int IMG_H  = 14,
    parameter int DATA_W = 16,
    parameter int WGT_W  = 16,
    parameter int OUT_W  = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_ifm,
    input  logic signed [WGT_W-1:0]  in_weight,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_ofm,
    output logic                     out_last,
    output logic                     busy
);
    localparam int PROD_W = DATA_W + WGT_W;
    localparam int CNT_CW = $clog2(IMG_W);
    localparam int CNT_RW = $clog2(IMG_H);
    localparam logic [CNT_CW-1:0] COL_LAST = CNT_CW'(IMG_W - 1);
    localparam logic [CNT_RW-1:0] ROW_LAST = CNT_RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state_q;
    logic                     drain_cnt_q;
    logic                     in_ready_q;
    logic                     busy_q;

    logic [CNT_CW-1:0]        col_q, col_d;
    logic [CNT_RW-1:0]        row_q, row_d;
    logic [3:0]               beat_q, beat_d;
    logic signed [WGT_W-1:0]  wgt_q [9];
    logic signed [WGT_W-1:0]  wgt_d [9];
    logic signed [DATA_W-1:0] lb0_q [IMG_W];
    logic signed [DATA_W-1:0] lb0_d [IMG_W];
    logic signed [DATA_W-1:0] lb1_q [IMG_W];
    logic signed [DATA_W-1:0] lb1_d [IMG_W];
    // Two older window columns, index row*2+col, col 0 is the oldest
    logic signed [DATA_W-1:0] win_q [6];
    logic signed [DATA_W-1:0] win_d [6];
    logic signed [PROD_W-1:0] prod_q [9];
    logic signed [PROD_W-1:0] prod_d [9];
    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_last_q, s1_last_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic signed [OUT_W-1:0]  ofm_q, ofm_d;

    logic                     w_accept;
    logic                     w_last_pix;
    logic                     w_win_ok;
    logic signed [DATA_W-1:0] w_tap [9];
    logic signed [WGT_W-1:0]  w_coef [9];
    logic signed [OUT_W-1:0]  w_sum;

    assign w_accept   = in_valid && in_ready_q;
    assign w_last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign w_win_ok   = (row_q >= CNT_RW'(2)) && (col_q >= CNT_CW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_accept && w_last_pix) begin
                        state_q     <= S_DRAIN;
                        in_ready_q  <= 1'b0;
                        drain_cnt_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q) begin
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        drain_cnt_q <= 1'b0;
                    end else begin
                        drain_cnt_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Newest window column comes straight from the line buffers and the live pixel;
    // the coefficient being captured this beat is bypassed so a 3-wide image works.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_tap[r*3]   = win_q[r*2];
            w_tap[r*3+1] = win_q[r*2+1];
        end
        w_tap[2] = lb1_q[col_q];
        w_tap[5] = lb0_q[col_q];
        w_tap[8] = in_ifm;
        for (int k = 0; k < 9; k++) begin
            w_coef[k] = (beat_q == 4'(k)) ? in_weight : wgt_q[k];
        end
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        beat_d = beat_q;
        wgt_d  = wgt_q;
        lb0_d  = lb0_q;
        lb1_d  = lb1_q;
        win_d  = win_q;
        if (w_accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int k = 0; k < 9; k++) begin
                if (beat_q == 4'(k)) wgt_d[k] = in_weight;
            end
            beat_d = w_last_pix ? 4'd0 : ((beat_q == 4'd9) ? beat_q : beat_q + 4'd1);
            lb1_d[col_q] = lb0_q[col_q];
            lb0_d[col_q] = in_ifm;
            for (int r = 0; r < 3; r++) begin
                win_d[r*2]   = win_q[r*2+1];
                win_d[r*2+1] = w_tap[r*3+2];
            end
        end
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = w_tap[k] * w_coef[k];
        end
        s1_valid_d = w_accept && w_win_ok;
        s1_last_d  = w_accept && w_last_pix;
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + {{(OUT_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
        end
`ifdef CONV_RELU_EN
        if (w_sum[OUT_W-1]) w_sum = '0;
`endif
        out_valid_d = s1_valid_q;
        out_last_d  = s1_last_q;
        ofm_d       = s1_valid_q ? w_sum : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            beat_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ofm_q       <= '0;
            for (int k = 0; k < 9; k++) begin
                wgt_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            for (int i = 0; i < 6; i++) win_q[i] <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            beat_q      <= beat_d;
            wgt_q       <= wgt_d;
            win_q       <= win_d;
            prod_q      <= prod_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            ofm_q       <= ofm_d;
        end
    end

    // Line buffer contents are only ever read behind a valid window, so no reset
    always_ff @(posedge clk) begin
        lb0_q <= lb0_d;
        lb1_q <= lb1_d;
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ofm   = ofm_q;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_stream_param
// Desc     : Self-checking bench for conv3x3_stream_param, reference model is a
//            direct 2-D valid-mode convolution over the driven image.
// Revision : 1.0
// ============================================================================
module tb_conv3x3_stream_param;
    localparam int IMG_W  = 14;
    localparam int IMG_H  = 14;
    localparam int DATA_W = 16;
    localparam int WGT_W  = 16;
    localparam int OUT_W  = 36;
    localparam int NOUT   = (IMG_W - 2) * (IMG_H - 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [DATA_W-1:0] in_ifm = '0;
    logic signed [WGT_W-1:0]  in_weight = '0;
    logic out_valid;
    logic signed [OUT_W-1:0]  out_ofm;
    logic out_last;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stall_cnt = 0;
    int img [IMG_H][IMG_W];
    int wgt [9];
    longint exp_ofm[$];
    longint got_ofm[$];
    int     exp_cyc[$];
    int     got_cyc[$];
    bit     got_last[$];

    conv3x3_stream_param #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .WGT_W(WGT_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ifm(in_ifm), .in_weight(in_weight), .out_valid(out_valid),
        .out_ofm(out_ofm), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            got_ofm.push_back(longint'(out_ofm));
            got_cyc.push_back(cyc);
            got_last.push_back(out_last);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_queues;
        exp_ofm.delete(); got_ofm.delete(); exp_cyc.delete();
        got_cyc.delete(); got_last.delete();
    endtask

    // Reference: plain valid-mode 3x3 convolution in raster order of outputs
    task automatic build_expected;
        for (int r = 2; r < IMG_H; r++) begin
            for (int c = 2; c < IMG_W; c++) begin
                longint s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += longint'(img[r-2+i][c-2+j]) * longint'(wgt[i*3+j]);
`ifdef CONV_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_ofm.push_back(s);
            end
        end
    endtask

    task automatic fill(input int p);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                case (p)
                    0:       img[r][c] = 1;
                    1, 2:    img[r][c] = r * IMG_W + c;
                    3:       img[r][c] = 2;
                    4:       img[r][c] = -32768;
                    default: img[r][c] = $urandom_range(65535) - 32768;
                endcase
        for (int k = 0; k < 9; k++)
            case (p)
                0:       wgt[k] = 1;
                1, 2:    wgt[k] = (k == 4) ? 1 : 0;
                3:       wgt[k] = -1;
                4:       wgt[k] = -32768;
                default: wgt[k] = $urandom_range(65535) - 32768;
            endcase
    endtask

    // Drives up to max_beats pixels; returns 1 time unit after the last accepting edge
    task automatic drive_frame(input int gap_pct, input int max_beats);
        int beat = 0;
        int guard = 0;
        while (beat < max_beats && guard < 20000) begin
            bit acc;
            int r = beat / IMG_W;
            int c = beat % IMG_W;
            guard++;
            in_valid  = ($urandom_range(99) >= gap_pct);
            in_ifm    = DATA_W'(img[r][c]);
            in_weight = (beat < 9) ? WGT_W'(wgt[beat]) : WGT_W'($urandom);
            acc = in_valid && in_ready;
            if (in_valid && !in_ready) stall_cnt++;
            if (acc && r >= 2 && c >= 2) exp_cyc.push_back(cyc + 1);
            @(posedge clk);
            if (acc) beat++;
            #1;
        end
        in_valid = 1'b0;
        if (beat < max_beats) begin
            n_checks++; n_fail++;
            $display("FAIL drive_timeout: accepted %0d beats, required %0d", beat, max_beats);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++;
        if (out_ofm !== '0) begin n_fail++; $display("FAIL reset_out_ofm: got %0d required 0", out_ofm); end
        n_checks++;
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b required 0", out_last); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_queues();
    endtask

    // ones, ramp/centre-tap, ramp with gaps, negative, extreme, random with gaps
    task automatic test_patterns;
        for (int p = 0; p < 6; p++) begin
            int gap = (p == 2) ? 50 : ((p == 5) ? 30 : 0);
            clear_queues();
            fill(p);
            build_expected();
            drive_frame(gap, IMG_W * IMG_H);
            repeat (5) @(posedge clk);
            #1;
            n_checks++;
            if (got_ofm.size() !== exp_ofm.size()) begin
                n_fail++;
                $display("FAIL pat%0d_count: got %0d outputs required %0d", p, got_ofm.size(), exp_ofm.size());
            end
            for (int i = 0; i < exp_ofm.size() && i < got_ofm.size(); i++) begin
                n_checks++;
                if (got_ofm[i] !== exp_ofm[i] || got_cyc[i] !== exp_cyc[i] + 1 ||
                    got_last[i] !== ((i + 1) % NOUT == 0)) begin
                    n_fail++;
                    $display("FAIL pat%0d_out%0d: got ofm %0d cyc %0d last %b required ofm %0d cyc %0d last %b",
                             p, i, got_ofm[i], got_cyc[i], got_last[i], exp_ofm[i], exp_cyc[i] + 1,
                             (i + 1) % NOUT == 0);
                end
            end
        end
    endtask

    task automatic test_last_busy;
        clear_queues();
        fill(0);
        drive_frame(0, IMG_W * IMG_H);
        @(negedge clk);
        n_checks++;
        if (out_last !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain1: got last %b busy %b ready %b required 0 1 0", out_last, busy, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (out_last !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain2: got last %b valid %b busy %b ready %b required 1 1 1 0",
                     out_last, out_valid, busy, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_ofm !== '0) begin
            n_fail++;
            $display("FAIL idle_after: got busy %b ready %b valid %b ofm %0d required 0 1 0 0",
                     busy, in_ready, out_valid, out_ofm);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        clear_queues();
        fill(5);
        drive_frame(0, 100);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_idle%0d: got valid %b busy %b ready %b required 0 0 1",
                         i, out_valid, busy, in_ready);
            end
        end
        @(posedge clk);
        #1;
        clear_queues();
        fill(5);
        build_expected();
        drive_frame(20, IMG_W * IMG_H);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (got_ofm.size() !== exp_ofm.size()) begin
            n_fail++;
            $display("FAIL rst_mid_count: got %0d outputs required %0d", got_ofm.size(), exp_ofm.size());
        end
        for (int i = 0; i < exp_ofm.size() && i < got_ofm.size(); i++) begin
            n_checks++;
            if (got_ofm[i] !== exp_ofm[i] || got_cyc[i] !== exp_cyc[i] + 1 ||
                got_last[i] !== ((i + 1) % NOUT == 0)) begin
                n_fail++;
                $display("FAIL rst_mid_out%0d: got ofm %0d cyc %0d last %b required ofm %0d cyc %0d",
                         i, got_ofm[i], got_cyc[i], got_last[i], exp_ofm[i], exp_cyc[i] + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        clear_queues();
        stall_cnt = 0;
        fill(5);
        build_expected();
        drive_frame(0, IMG_W * IMG_H);
        fill(5);
        build_expected();
        drive_frame(0, IMG_W * IMG_H);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (stall_cnt !== 2) begin
            n_fail++;
            $display("FAIL b2b_stalls: got %0d stall cycles required 2", stall_cnt);
        end
        n_checks++;
        if (got_ofm.size() !== exp_ofm.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs required %0d", got_ofm.size(), exp_ofm.size());
        end
        for (int i = 0; i < exp_ofm.size() && i < got_ofm.size(); i++) begin
            n_checks++;
            if (got_ofm[i] !== exp_ofm[i] || got_cyc[i] !== exp_cyc[i] + 1 ||
                got_last[i] !== ((i + 1) % NOUT == 0)) begin
                n_fail++;
                $display("FAIL b2b_out%0d: got ofm %0d cyc %0d last %b required ofm %0d cyc %0d",
                         i, got_ofm[i], got_cyc[i], got_last[i], exp_ofm[i], exp_cyc[i] + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_last_busy();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
